// File: rtl/ddc_accum_pkg.sv
// Shared types, default widths and lane helpers for the integrate-and-dump decimator.
// The accumulator width is always derived from the sample and rate widths.
package ddc_accum_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_IN_W   = 16;
  localparam int DEF_RATE_W = 16;

  // IN_W+RATE_W bits hold the sum of up to 2^RATE_W-1 full-scale samples without wrap.
  function automatic int acc_w(input int in_w, input int rate_w);
    return in_w + rate_w;
  endfunction

  localparam int DEF_ACC_W = acc_w(DEF_IN_W, DEF_RATE_W);

  typedef logic signed [DEF_IN_W-1:0] sample_t;

  typedef struct packed {
    logic signed [DEF_ACC_W-1:0] q;
    logic signed [DEF_ACC_W-1:0] i;
  } iq_acc_t;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  function automatic logic [2*DEF_IN_W-1:0] lane_pack(input sample_t q, input sample_t i);
    return {q, i};
  endfunction

  function automatic sample_t lane_i(input logic [2*DEF_IN_W-1:0] lane);
    return sample_t'(lane[DEF_IN_W-1:0]);
  endfunction

  function automatic sample_t lane_q(input logic [2*DEF_IN_W-1:0] lane);
    return sample_t'(lane[2*DEF_IN_W-1:DEF_IN_W]);
  endfunction

endpackage

// File: rtl/ddc_accum_serializer.sv
// Hold bank for one completed frame plus the FSM that streams it out one channel per beat.
// Detects frames completing while the previous one is still draining.
module ddc_accum_serializer
  import ddc_accum_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CH_W  = 2
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic                     dump,
  input  logic [N_CH*2*ACC_W-1:0]  dump_data,
  input  logic                     resync,
  output logic [2*ACC_W-1:0]       m_axis_tdata,
  output logic [CH_W-1:0]          m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     overflow
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [2*ACC_W-1:0] hold [N_CH];
  logic               hold_full;
  ser_state_e         state, state_nxt;
  logic [CH_W-1:0]    ch, ch_nxt;
  logic               hs, tlast_hs, take, overrun;

  assign m_axis_tvalid = (state == SER_SEND);
  assign m_axis_tuser  = ch;
  assign m_axis_tlast  = m_axis_tvalid && (ch == LAST_CH);
  assign m_axis_tdata  = m_axis_tvalid ? hold[ch] : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    ch_nxt    = ch;
    hs        = m_axis_tvalid && m_axis_tready;
    tlast_hs  = hs && m_axis_tlast;
    // The bank is free this cycle if empty or its last beat is leaving right now.
    take      = dump && (!hold_full || tlast_hs);
    overrun   = dump && hold_full && !tlast_hs;
    case (state)
      SER_IDLE: begin
        if (take || hold_full) begin
          state_nxt = SER_SEND;
          ch_nxt    = '0;
        end
      end
      SER_SEND: begin
        if (hs) begin
          if (ch == LAST_CH) begin
            ch_nxt    = '0;
            state_nxt = take ? SER_SEND : SER_IDLE;
          end else begin
            ch_nxt = ch + CH_W'(1);
          end
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state     <= SER_IDLE;
      ch        <= '0;
      hold_full <= 1'b0;
      overflow  <= 1'b0;
      // NOTE: the hold bank is a few flops, not a RAM; resetting it guarantees zero output data after reset.
      for (int c = 0; c < N_CH; c++) hold[c] <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      if (take) begin
        hold_full <= 1'b1;
        for (int c = 0; c < N_CH; c++) hold[c] <= dump_data[2*ACC_W*c +: 2*ACC_W];
      end else if (tlast_hs) begin
        hold_full <= 1'b0;
      end
      if (resync)       overflow <= 1'b0;
      else if (overrun) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ddc_accum_dump.sv
// Integrate-and-dump decimator: per-channel I/Q accumulators over a programmable frame
// length, handing each completed frame to the serializer. The input is never stalled.
module ddc_accum_dump
  import ddc_accum_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int IN_W   = DEF_IN_W,
  parameter  int RATE_W = DEF_RATE_W,
  localparam int ACC_W  = acc_w(IN_W, RATE_W),
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic [RATE_W-1:0]        ds_rate,
  input  logic                     enable,
  input  logic                     resync,
  input  logic [N_CH*2*IN_W-1:0]   s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [2*ACC_W-1:0]       m_axis_tdata,
  output logic [CH_W-1:0]          m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     overflow
);

  logic [RATE_W-1:0] cnt, rate_q, rate_now, frame_rate;
  logic              accept, clear, last_beat, dump;
  logic [IN_W-1:0]   smp_i [N_CH];
  logic [IN_W-1:0]   smp_q [N_CH];
  logic [ACC_W-1:0]  acc_i [N_CH];
  logic [ACC_W-1:0]  acc_q [N_CH];
  logic [ACC_W-1:0]  sum_i [N_CH];
  logic [ACC_W-1:0]  sum_q [N_CH];
  logic [N_CH*2*ACC_W-1:0] dump_data;

  always_comb begin
    // NOTE: combinational logic uses blocking '='; registers below use '<=' so all flops update together.
    rate_now   = (ds_rate == '0) ? RATE_W'(1) : ds_rate;
    // The first beat of a frame sees the freshly latched rate; later beats use the held copy.
    frame_rate = (cnt == '0) ? rate_now : rate_q;
    accept     = s_axis_tvalid && s_axis_tready && enable;
    clear      = !enable || resync;
    last_beat  = (cnt == frame_rate - RATE_W'(1));
    dump       = accept && last_beat && !resync;
    dump_data  = '0;
    for (int c = 0; c < N_CH; c++) begin
      smp_i[c] = s_axis_tdata[2*IN_W*c +: IN_W];
      smp_q[c] = s_axis_tdata[2*IN_W*c + IN_W +: IN_W];
      sum_i[c] = acc_i[c] + {{RATE_W{smp_i[c][IN_W-1]}}, smp_i[c]};
      sum_q[c] = acc_q[c] + {{RATE_W{smp_q[c][IN_W-1]}}, smp_q[c]};
      dump_data[2*ACC_W*c +: 2*ACC_W] = {sum_q[c], sum_i[c]};
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      s_axis_tready <= 1'b0;
      cnt           <= '0;
      rate_q        <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc_i[c] <= '0;
        acc_q[c] <= '0;
      end
    end else begin
      s_axis_tready <= 1'b1;
      if (clear) begin
        cnt <= '0;
        for (int c = 0; c < N_CH; c++) begin
          acc_i[c] <= '0;
          acc_q[c] <= '0;
        end
      end else if (accept) begin
        if (cnt == '0) rate_q <= rate_now;
        if (last_beat) begin
          cnt <= '0;
          for (int c = 0; c < N_CH; c++) begin
            acc_i[c] <= '0;
            acc_q[c] <= '0;
          end
        end else begin
          cnt <= cnt + RATE_W'(1);
          for (int c = 0; c < N_CH; c++) begin
            acc_i[c] <= sum_i[c];
            acc_q[c] <= sum_q[c];
          end
        end
      end
    end
  end

  ddc_accum_serializer #(
    .N_CH  (N_CH),
    .ACC_W (ACC_W),
    .CH_W  (CH_W)
  ) u_serializer (
    .s_axis_aclk    (s_axis_aclk),
    .s_axis_aresetn (s_axis_aresetn),
    .dump           (dump),
    .dump_data      (dump_data),
    .resync         (resync),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .overflow       (overflow)
  );

endmodule

// File: tb/tb_ddc_accum_dump.sv
// Scoreboard bench for ddc_accum_dump: a frame-level model predicts output beats and the
// overflow flag; a negedge monitor checks every handshake, stall stability and flags.
module tb_ddc_accum_dump;
  import ddc_accum_pkg::*;

  localparam int N_CH   = DEF_N_CH;
  localparam int IN_W   = DEF_IN_W;
  localparam int RATE_W = DEF_RATE_W;
  localparam int ACC_W  = DEF_ACC_W;
  localparam int CH_W   = 2;
  localparam int DW     = N_CH*2*IN_W;

  logic              s_axis_aclk = 1'b0;
  logic              s_axis_aresetn = 1'b0;
  logic [RATE_W-1:0] ds_rate = '0;
  logic              enable = 1'b0;
  logic              resync = 1'b0;
  logic [DW-1:0]     s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [2*ACC_W-1:0] m_axis_tdata;
  logic [CH_W-1:0]   m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              overflow;

  ddc_accum_dump #(.N_CH(N_CH), .IN_W(IN_W), .RATE_W(RATE_W)) dut (
    .s_axis_aclk    (s_axis_aclk),
    .s_axis_aresetn (s_axis_aresetn),
    .ds_rate        (ds_rate),
    .enable         (enable),
    .resync         (resync),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .overflow       (overflow)
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  typedef struct packed {
    logic [2*ACC_W-1:0] data;
    logic [CH_W-1:0]    user;
    logic               last;
  } beat_t;

  beat_t  exp_q[$];
  int     n_vec = 0;
  int     n_fail = 0;
  longint m_sum_i [N_CH];
  longint m_sum_q [N_CH];
  int     m_cnt = 0;
  int     m_rate = 1;
  int     m_left = 0;
  bit     exp_ovf = 1'b0;
  bit     ovf_now = 1'b0;
  bit     rdy_chk = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_frame();
    for (int c = 0; c < N_CH; c++) begin
      m_sum_i[c] = 0;
      m_sum_q[c] = 0;
    end
    m_cnt = 0;
  endtask

  // Frame-level model of what the next clock edge does, from the inputs now applied.
  task automatic model_step();
    logic [2*IN_W-1:0] lane;
    iq_acc_t           e;
    ovf_now = exp_ovf;
    if (m_left > 0 && m_axis_tready) m_left--;
    if (resync || !enable) begin
      clear_frame();
      if (resync) exp_ovf = 1'b0;
    end else if (s_axis_tvalid) begin
      if (m_cnt == 0) m_rate = (ds_rate == '0) ? 1 : int'(ds_rate);
      for (int c = 0; c < N_CH; c++) begin
        lane = s_axis_tdata[2*IN_W*c +: 2*IN_W];
        m_sum_i[c] += longint'(lane_i(lane));
        m_sum_q[c] += longint'(lane_q(lane));
      end
      m_cnt++;
      if (m_cnt == m_rate) begin
        if (m_left != 0) begin
          exp_ovf = 1'b1;
        end else begin
          for (int c = 0; c < N_CH; c++) begin
            e.i = m_sum_i[c][ACC_W-1:0];
            e.q = m_sum_q[c][ACC_W-1:0];
            exp_q.push_back('{data: e, user: CH_W'(c), last: (c == N_CH-1)});
          end
          m_left = N_CH;
        end
        clear_frame();
      end
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit en, input bit rs,
                       input logic [RATE_W-1:0] r, input bit mr);
    @(posedge s_axis_aclk);
    #1;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    enable        = en;
    resync        = rs;
    ds_rate       = r;
    m_axis_tready = mr;
    model_step();
  endtask

  function automatic logic [DW-1:0] rand_lanes();
    logic [DW-1:0] d;
    for (int c = 0; c < N_CH; c++) d[2*IN_W*c +: 2*IN_W] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] const_lanes(input sample_t q, input sample_t i);
    logic [DW-1:0] d;
    for (int c = 0; c < N_CH; c++) d[2*IN_W*c +: 2*IN_W] = lane_pack(q, i);
    return d;
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks flags and stall stability.
  logic               prev_v = 1'b0;
  logic               prev_r = 1'b0;
  logic [2*ACC_W-1:0] prev_d = '0;
  logic [CH_W-1:0]    prev_u = '0;
  logic               prev_l = 1'b0;

  always @(negedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      prev_v = 1'b0;
    end else begin
      if (rdy_chk) check("s_axis_tready", 128'(s_axis_tready), 128'(1));
      check("overflow", 128'(overflow), 128'(ovf_now));
      if (prev_v && !prev_r) begin
        check("stall_ctrl", {m_axis_tvalid, m_axis_tuser, m_axis_tlast}, {1'b1, prev_u, prev_l});
        check("stall_data", 128'(m_axis_tdata), 128'(prev_d));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL beat_unexpected: got user %0d data %0h with nothing expected at %0t",
                   m_axis_tuser, m_axis_tdata, $time);
        end else begin
          check("beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, exp_q.pop_front());
        end
      end
      prev_v = m_axis_tvalid;
      prev_r = m_axis_tready;
      prev_d = m_axis_tdata;
      prev_u = m_axis_tuser;
      prev_l = m_axis_tlast;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    bit found;
    clear_frame();
    #12;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tdata", 128'(m_axis_tdata), 128'(0));
    check("rst_tuser", 128'(m_axis_tuser), 128'(0));
    check("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_s_tready", 128'(s_axis_tready), 128'(0));
    @(posedge s_axis_aclk);
    #1;
    s_axis_aresetn = 1'b1;
    check("s_tready_before_edge", 128'(s_axis_tready), 128'(0));
    @(posedge s_axis_aclk);
    #1;
    check("s_tready_rise", 128'(s_axis_tready), 128'(1));
    rdy_chk = 1'b1;

    // Constant lanes I=+100, Q=-50 at rate 32: three frames of 3200/-1600.
    d = const_lanes(-16'sd50, 16'sd100);
    for (int i = 0; i < 96; i++) drive(1'b1, d, 1'b1, 1'b0, 16'd32, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd32, 1'b1);

    // Full-scale negative I over the maximum rate must not wrap.
    d = const_lanes(16'sd32767, -16'sd32768);
    for (int i = 0; i < 65535; i++) drive(1'b1, d, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd4, 1'b1);

    // rate == N_CH is lossless (tlast and dump coincide); rate 2 overruns.
    for (int i = 0; i < 40; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd4, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd2, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd2, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1, 16'd32, 1'b1);

    // Downstream stall from the first beat: first frame held stable, second dropped.
    for (int i = 0; i < 80; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd32, (i >= 70));
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd32, 1'b1);

    // Resync ten beats into a frame; then a rate change mid-frame.
    for (int i = 0; i < 10; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd32, 1'b1);
    drive(1'b1, rand_lanes(), 1'b1, 1'b1, 16'd32, 1'b1);
    for (int i = 0; i < 32; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd32, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd32, 1'b1);
    for (int i = 0; i < 43; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd8, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd8, 1'b1);

    // Random traffic, enable gaps, resyncs, rates 0..9 and backpressure.
    for (int i = 0; i < 1500; i++)
      drive(($urandom % 4) != 0, rand_lanes(), ($urandom % 16) != 0, ($urandom % 64) == 0,
            RATE_W'($urandom_range(0, 9)), ($urandom % 3) != 0);
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd4, 1'b1);

    // Set overflow with a held frame, then reset in the middle of sending it.
    for (int i = 0; i < 8; i++) drive(1'b1, rand_lanes(), 1'b1, 1'b0, 16'd4, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 16'd4, 1'b1);
      found = m_axis_tvalid && (m_axis_tuser == CH_W'(1));
    end
    check("reach_tuser1", 128'(found), 128'(1));
    s_axis_aresetn = 1'b0;
    #1;
    check("async_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("async_tdata", 128'(m_axis_tdata), 128'(0));
    check("async_overflow", 128'(overflow), 128'(0));
    exp_q.delete();
    m_left  = 0;
    exp_ovf = 1'b0;
    ovf_now = 1'b0;
    rdy_chk = 1'b0;
    clear_frame();
    repeat (2) @(posedge s_axis_aclk);
    #1;
    s_axis_aresetn = 1'b1;
    check("s_tready_after_rst", 128'(s_axis_tready), 128'(0));
    @(posedge s_axis_aclk);
    #1;
    check("s_tready_rerise", 128'(s_axis_tready), 128'(1));
    rdy_chk = 1'b1;
    for (int i = 0; i < 12; i++) drive(1'b0, '0, 1'b1, 1'b0, 16'd4, 1'b1);

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
